// File: rtl/hilo_sequencer.sv
// HI/LO sequencer: runs the iterative mult/div units for a fixed cycle count
// and owns the architectural HI/LO registers.
module hilo_sequencer #(
    parameter int unsigned MULT_LATENCY = 33,
    parameter int unsigned DIV_LATENCY  = 33
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Op_Start,
    input  logic        Op_Sel,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Hilo_Write,
    input  logic        Hilo_Sel,
    input  logic [31:0] Hilo_Data,
    input  logic [31:0] Mult_HI,
    input  logic [31:0] Mult_LO,
    input  logic [31:0] Div_HI,
    input  logic [31:0] Div_LO,
    output logic        Unit_Mult_Control,
    output logic        Unit_Div_Control,
    output logic [31:0] Unit_A,
    output logic [31:0] Unit_B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy,
    output logic        Done,
    output logic        Div_Zero
);

    typedef enum logic [1:0] {
        IDLE,
        RUN_M,
        RUN_D,
        CAPTURE
    } state_t;

    localparam logic [5:0] M_LAST = 6'(MULT_LATENCY - 1);
    localparam logic [5:0] D_LAST = 6'(DIV_LATENCY - 1);

    state_t     state;
    state_t     state_next;
    logic [5:0] count;
    logic       sel;
    logic       accept;
    logic       div_by_zero;

    assign div_by_zero = Op_Start && Op_Sel && (B == 32'd0);
    assign accept      = Op_Start && !div_by_zero;

    // State register; reset abandons any operation in flight.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and unit control decode.
    always_comb begin
        state_next        = state;
        Unit_Mult_Control = 1'b0;
        Unit_Div_Control  = 1'b0;
        Busy              = 1'b1;
        unique case (state)
            IDLE: begin
                Busy = 1'b0;
                if (accept) begin
                    state_next = Op_Sel ? RUN_D : RUN_M;
                end
            end
            RUN_M: begin
                Unit_Mult_Control = 1'b1;
                if (count == M_LAST) begin
                    state_next = CAPTURE;
                end
            end
            RUN_D: begin
                Unit_Div_Control = 1'b1;
                if (count == D_LAST) begin
                    state_next = CAPTURE;
                end
            end
            CAPTURE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand latch, cycle counter, HI/LO update and event pulses.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            count    <= 6'd0;
            sel      <= 1'b0;
            Unit_A   <= 32'd0;
            Unit_B   <= 32'd0;
            HI       <= 32'd0;
            LO       <= 32'd0;
            Done     <= 1'b0;
            Div_Zero <= 1'b0;
        end else begin
            Done     <= 1'b0;
            Div_Zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (Hilo_Write) begin
                        if (Hilo_Sel) begin
                            HI <= Hilo_Data;
                        end else begin
                            LO <= Hilo_Data;
                        end
                    end
                    if (accept) begin
                        Unit_A <= A;
                        Unit_B <= B;
                        sel    <= Op_Sel;
                        count  <= 6'd0;
                    end
                    if (div_by_zero) begin
                        Div_Zero <= 1'b1;
                    end
                end
                RUN_M, RUN_D: begin
                    count <= count + 6'd1;
                end
                CAPTURE: begin
                    HI   <= sel ? Div_HI : Mult_HI;
                    LO   <= sel ? Div_LO : Mult_LO;
                    Done <= 1'b1;
                end
                default: begin
                    count <= 6'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_sequencer.sv
// Directed bench for hilo_sequencer with behavioural mult/div units.
module tb_hilo_sequencer;

    logic        Clock;
    logic        Reset;
    logic        Op_Start;
    logic        Op_Sel;
    logic [31:0] A;
    logic [31:0] B;
    logic        Hilo_Write;
    logic        Hilo_Sel;
    logic [31:0] Hilo_Data;
    logic [31:0] Mult_HI;
    logic [31:0] Mult_LO;
    logic [31:0] Div_HI;
    logic [31:0] Div_LO;
    logic        Unit_Mult_Control;
    logic        Unit_Div_Control;
    logic [31:0] Unit_A;
    logic [31:0] Unit_B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        Busy;
    logic        Done;
    logic        Div_Zero;

    int n_run;
    int n_fail;

    int r_ctl_m;
    int r_ctl_d;
    int r_first;
    int r_last;
    int r_busy;
    int r_done_k;
    int r_done_n;
    int r_dz_k;
    int r_dz_n;
    int r_both;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    hilo_sequencer #(
        .MULT_LATENCY(33),
        .DIV_LATENCY (33)
    ) dut (
        .Clock            (Clock),
        .Reset            (Reset),
        .Op_Start         (Op_Start),
        .Op_Sel           (Op_Sel),
        .A                (A),
        .B                (B),
        .Hilo_Write       (Hilo_Write),
        .Hilo_Sel         (Hilo_Sel),
        .Hilo_Data        (Hilo_Data),
        .Mult_HI          (Mult_HI),
        .Mult_LO          (Mult_LO),
        .Div_HI           (Div_HI),
        .Div_LO           (Div_LO),
        .Unit_Mult_Control(Unit_Mult_Control),
        .Unit_Div_Control (Unit_Div_Control),
        .Unit_A           (Unit_A),
        .Unit_B           (Unit_B),
        .HI               (HI),
        .LO               (LO),
        .Busy             (Busy),
        .Done             (Done),
        .Div_Zero         (Div_Zero)
    );

    // Behavioural arithmetic units driven from the latched operands.
    logic [63:0] prod;
    assign prod    = {32'd0, Unit_A} * {32'd0, Unit_B};
    assign Mult_HI = prod[63:32];
    assign Mult_LO = prod[31:0];
    assign Div_LO  = (Unit_B == 32'd0) ? 32'd0 : Unit_A / Unit_B;
    assign Div_HI  = (Unit_B == 32'd0) ? 32'd0 : Unit_A % Unit_B;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic hilo_wr(input logic s, input logic [31:0] d);
        @(negedge Clock);
        Hilo_Write = 1'b1;
        Hilo_Sel   = s;
        Hilo_Data  = d;
        @(negedge Clock);
        Hilo_Write = 1'b0;
    endtask

    // Issue one request at edge t, then observe cycles t+1..t+40.
    // inj_k: cycle to issue a stray Op_Start + mthi; rst_k: cycle to reset;
    // wr_done: issue mtlo 0x55 in the Done cycle.
    task automatic run_op(input logic sel, input logic [31:0] a,
                          input logic [31:0] b, input int inj_k,
                          input int rst_k, input logic wr_done);
        r_ctl_m  = 0;
        r_ctl_d  = 0;
        r_first  = 0;
        r_last   = 0;
        r_busy   = 0;
        r_done_k = 0;
        r_done_n = 0;
        r_dz_k   = 0;
        r_dz_n   = 0;
        r_both   = 0;
        r_hi     = 32'd0;
        r_lo     = 32'd0;
        @(negedge Clock);
        Op_Start = 1'b1;
        Op_Sel   = sel;
        A        = a;
        B        = b;
        @(posedge Clock);
        #1;
        Op_Start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge Clock);
            Op_Start   = 1'b0;
            Hilo_Write = 1'b0;
            if (Unit_Mult_Control) begin
                r_ctl_m++;
                if (r_first == 0) r_first = k;
                r_last = k;
            end
            if (Unit_Div_Control) begin
                r_ctl_d++;
                if (r_first == 0) r_first = k;
                r_last = k;
            end
            if (Busy) r_busy++;
            if (Done && Div_Zero) r_both++;
            if (Div_Zero) begin
                r_dz_n++;
                if (r_dz_k == 0) r_dz_k = k;
            end
            if (Done) begin
                r_done_n++;
                if (r_done_k == 0) begin
                    r_done_k = k;
                    r_hi     = HI;
                    r_lo     = LO;
                end
                if (wr_done) begin
                    Hilo_Write = 1'b1;
                    Hilo_Sel   = 1'b0;
                    Hilo_Data  = 32'h55;
                end
            end
            if (k == inj_k) begin
                Op_Start   = 1'b1;
                Op_Sel     = 1'b1;
                A          = 32'd999;
                B          = 32'd3;
                Hilo_Write = 1'b1;
                Hilo_Sel   = 1'b1;
                Hilo_Data  = 32'hDEAD;
            end
            if (k == rst_k) begin
                Reset = 1'b0;
                #1;
                check("rst_busy", 64'(Busy), 64'd0);
                check("rst_ctl", {62'd0, Unit_Mult_Control,
                      Unit_Div_Control}, 64'd0);
                check("rst_hilo", {HI, LO}, 64'd0);
                check("rst_ops", {Unit_A, Unit_B}, 64'd0);
                check("rst_pulse", {62'd0, Done, Div_Zero}, 64'd0);
            end
        end
        @(negedge Clock);
        Hilo_Write = 1'b0;
        Reset      = 1'b1;
    endtask

    initial begin
        n_run      = 0;
        n_fail     = 0;
        Reset      = 1'b0;
        Op_Start   = 1'b0;
        Op_Sel     = 1'b0;
        A          = 32'd0;
        B          = 32'd0;
        Hilo_Write = 1'b0;
        Hilo_Sel   = 1'b0;
        Hilo_Data  = 32'd0;
        #12;
        check("init_hilo", {HI, LO}, 64'd0);
        check("init_ctl", {61'd0, Unit_Mult_Control, Unit_Div_Control,
              Busy}, 64'd0);
        @(negedge Clock);
        Reset = 1'b1;

        // Mult 6*2
        run_op(1'b0, 32'd6, 32'd2, 0, 0, 1'b0);
        check("m1_ctl_n", 64'(r_ctl_m), 64'd33);
        check("m1_ctl_span", {32'(r_first), 32'(r_last)}, {32'd1, 32'd33});
        check("m1_div_ctl", 64'(r_ctl_d), 64'd0);
        check("m1_busy", 64'(r_busy), 64'd34);
        check("m1_done", {32'(r_done_k), 32'(r_done_n)}, {32'd35, 32'd1});
        check("m1_hilo", {r_hi, r_lo}, 64'h00000000_0000000C);

        // Larger mult, with mtlo in the Done cycle
        run_op(1'b0, 32'h00100400, 32'h00000420, 0, 0, 1'b1);
        check("m2_busy", 64'(r_busy), 64'd34);
        check("m2_hilo", {r_hi, r_lo}, 64'h00000000_42108000);
        check("m2_wr_wins", {HI, LO}, 64'h00000000_00000055);

        // Div 100/7
        run_op(1'b1, 32'd100, 32'd7, 0, 0, 1'b0);
        check("d1_ctl_n", 64'(r_ctl_d), 64'd33);
        check("d1_mult_ctl", 64'(r_ctl_m), 64'd0);
        check("d1_done", {32'(r_done_k), 32'(r_done_n)}, {32'd35, 32'd1});
        check("d1_hilo", {r_hi, r_lo}, {32'd2, 32'd14});
        check("d1_no_dz", 64'(r_dz_n), 64'd0);

        // Divide by zero with preloaded HI/LO
        hilo_wr(1'b1, 32'h11);
        hilo_wr(1'b0, 32'h22);
        check("pre_hilo", {HI, LO}, {32'h11, 32'h22});
        run_op(1'b1, 32'd7, 32'd0, 0, 0, 1'b0);
        check("dz_pulse", {32'(r_dz_k), 32'(r_dz_n)}, {32'd1, 32'd1});
        check("dz_busy", 64'(r_busy), 64'd0);
        check("dz_no_done", 64'(r_done_n), 64'd0);
        check("dz_no_unit", 64'(r_ctl_d + r_ctl_m), 64'd0);
        check("dz_hilo", {HI, LO}, {32'h11, 32'h22});

        // Stray Op_Start and mthi mid-mult
        run_op(1'b0, 32'd6, 32'd2, 10, 0, 1'b0);
        check("inj_ctl", {32'(r_ctl_m), 32'(r_ctl_d)}, {32'd33, 32'd0});
        check("inj_busy", 64'(r_busy), 64'd34);
        check("inj_done", {32'(r_done_k), 32'(r_done_n)}, {32'd35, 32'd1});
        check("inj_hilo", {r_hi, r_lo}, 64'h00000000_0000000C);
        check("inj_ops", {Unit_A, Unit_B}, {32'd6, 32'd2});

        // Reset mid-mult, then a fresh mult
        run_op(1'b0, 32'd6, 32'd2, 0, 15, 1'b0);
        check("rst_no_done", 64'(r_done_n), 64'd0);
        run_op(1'b0, 32'd3, 32'd5, 0, 0, 1'b0);
        check("post_done", {32'(r_done_k), 32'(r_done_n)}, {32'd35, 32'd1});
        check("post_hilo", {r_hi, r_lo}, {32'd0, 32'd15});

        check("never_both", 64'(r_both), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_sequencer.md
Name: hilo_sequencer

Overview:
- Sequences the iterative multiply and divide units on behalf of the CPU control unit and owns the architectural HI/LO registers.
- Accepts a one-cycle start request, latches the operands, and drives each unit's level-sensitive control line for an exact cycle count.
- Captures the selected unit's HI/LO result, pulses Done, and flags divide-by-zero without starting the divider.
- Also services mthi/mtlo writes and exposes Busy so the control unit stalls mfhi/mflo and new mult/div requests.

Parameters:
MULT_LATENCY, 33, cycles Unit_Mult_Control is held high before the Mult result is valid (range 2..63)
DIV_LATENCY, 33, cycles Unit_Div_Control is held high before the Div result is valid (range 2..63)

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  asynchronous, active-low reset
Op_Start  in  1  single-cycle request to begin an operation
Op_Sel  in  1  0 = multiply, 1 = divide; sampled with Op_Start
A  in  32  operand A (multiplicand / dividend), sampled with Op_Start
B  in  32  operand B (multiplier / divisor), sampled with Op_Start
Hilo_Write  in  1  mthi/mtlo write strobe
Hilo_Sel  in  1  0 = write LO, 1 = write HI
Hilo_Data  in  32  data for mthi/mtlo
Mult_HI, Mult_LO  in  32 each  result outputs of Mult unit
Div_HI, Div_LO  in  32 each  result outputs of Div unit (HI = remainder, LO = quotient)
Unit_Mult_Control  out  1  level control to Mult unit
Unit_Div_Control  out  1  level control to Div unit
Unit_A, Unit_B  out  32 each  latched operands to both units
HI, LO  out  32 each  architectural HI/LO registers
Busy  out  1  high while state != IDLE (combinational from state)
Done  out  1  one-cycle pulse; HI/LO hold new result in same cycle
Div_Zero  out  1  one-cycle pulse; divide requested with B == 0

Behaviour:
- Reset low (async): state to IDLE; counter, Unit_A, Unit_B, HI, LO cleared to 0; both unit controls, Done, Div_Zero driven to 0. An in-flight operation is abandoned and its result is never written.
- States and transitions:
  - IDLE:
    - Op_Start with Op_Sel = 0: latch A/B into Unit_A/Unit_B, clear counter, go to RUN_M.
    - Op_Start with Op_Sel = 1 and B != 0: latch operands, clear counter, go to RUN_D.
    - Op_Start with Op_Sel = 1 and B == 0: stay in IDLE; Div_Zero pulses the next cycle; HI/LO unchanged; no unit started.
  - RUN_M / RUN_D:
    - The matching unit control is high in every cycle of this state; the other control stays low.
    - Counter increments each cycle.
    - When counter == LATENCY-1, go to CAPTURE. The control is therefore high for exactly LATENCY cycles and is already low in CAPTURE.
  - CAPTURE:
    - Both controls low.
    - At the exiting edge, HI/LO load from the unit selected by the latched Op_Sel, Done is registered high, and state returns to IDLE.
- Latency, with Op_Start sampled at edge t:
  - Busy is high from t+1 for LATENCY+1 cycles.
  - Done and new HI/LO are visible in cycle t+LATENCY+2.
- Op_Start while Busy: ignored, not queued; the bench must see no change to the operation in flight.
- Hilo_Write:
  - Applied only in IDLE; dropped while Busy.
  - Simultaneous with an accepted Op_Start: the write is applied, then overwritten at CAPTURE.
  - Simultaneous with the Done cycle: the write wins, since it lands on the following edge.
- Operands are not re-sampled during RUN; A/B changes mid-operation have no effect.
- Counter is 6 bits; no wrap within the legal LATENCY range.
- Done and Div_Zero are never high in the same cycle. Each is high for exactly one cycle per event.

Test Plan:
- Mult, LATENCY 33, behavioural Mult model: A=6, B=2, Op_Start at t -> Unit_Mult_Control high t+1..t+33; Done at t+35; HI=0x00000000, LO=0x0000000C.
- Mult: A=0x00100400, B=0x00000420 -> HI=0x00000000, LO=0x42108000; Busy high for 34 cycles.
- Div: A=100, B=7 -> Unit_Div_Control high 33 cycles, Unit_Mult_Control never high; Done at t+35; HI=2, LO=14.
- Div-by-zero, with HI=0x11, LO=0x22 preloaded via Hilo_Write: A=7, B=0 -> Div_Zero pulse at t+1; Busy stays low; HI/LO still 0x11/0x22.
- Op_Start and Hilo_Write(HI, 0xDEAD) issued at t+10 during a mult -> both ignored; result and timing identical to the first scenario.
- Reset driven low at t+15 during a mult -> asynchronous return to IDLE with all outputs 0; no Done pulse; a fresh mult after release completes normally.
